seg_write_back: RTL and testbench
=================================

# seg_write_back

Write-back stage of the five-stage MIPS pipeline. It sits directly downstream of the memory-access stage and holds the MEM/WB pipeline register. It selects the register-file write data (loaded word or ALU result) and drives the register-file write port. It also tracks retired instructions and halts the pipeline's commit point when a HALT instruction retires.

## Interface
- LEN, 32, datapath width
- NB_ADDR, 5, register-index width
- NB_CTRL_WB, 2, write-back control bus width: bit1 RegWrite, bit0 MemtoReg
- NB_CNT, 32, retired-instruction counter width
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = pipeline advances this edge; 0 = stall (hold)
- i_flush  in  1  1 = load a bubble into MEM/WB; has priority over i_enable
- i_valid  in  1  MEM stage holds a real instruction
- i_halt  in  1  MEM-stage instruction is HALT
- i_read_data  in  LEN  data-memory output (synchronous RAM; valid in the cycle after MEM presented the address, i.e. while the load sits in WB)
- i_address  in  LEN  ALU result from MEM
- i_write_register  in  NB_ADDR  destination register from MEM
- i_ctrl_wb_bus  in  NB_CTRL_WB  {RegWrite, MemtoReg} from MEM
- o_reg_write  out  1  register-file write enable
- o_write_register  out  NB_ADDR  register-file write index
- o_write_data  out  LEN  register-file write data (also the forwarding source)
- o_wb_valid  out  1  WB holds a real instruction
- o_halted  out  1  sticky; a HALT has retired
- o_retired_count  out  NB_CNT  instructions retired since reset

## Operation
- MEM/WB latch fields: valid, halt, address, write_register, ctrl.
  - Edge with i_flush=1: valid, halt and ctrl are cleared; the other fields are don't-care.
  - Edge with i_flush=0, i_enable=1: all fields load from the inputs. If i_valid=0, ctrl and halt load 0.
  - Edge with i_flush=0, i_enable=0: all fields hold.
- Read-data hold register (hold_data, hold_valid):
  - On an edge with i_enable=0, i_flush=0 and hold_valid=0: hold_data<=i_read_data and hold_valid<=1.
  - hold_valid clears on any edge with i_enable=1 or i_flush=1.
  - Selected read data = hold_valid ? hold_data : i_read_data. This keeps a stalled load stable even if RAM output changes.
- o_write_data = MemtoReg ? selected read data : latched address.
- o_reg_write = valid & RegWrite & (write_register != 0) & (state == RUN). Writes to $0 are suppressed.
- Commit FSM, states RUN and HALTED:
  - Retire event = state==RUN & valid & i_enable & ~i_flush.
  - On a retire event: the counter increments, saturating at all ones. If the latched halt=1, the state moves to HALTED.
  - HALTED is left only by reset. In HALTED the latch, counter and hold register freeze, and i_enable and i_flush are ignored.
- o_halted = (state == HALTED).
- o_wb_valid = latched valid.

## Timing
- Reset (i_rst=0, asynchronous) clears all latch fields, hold register, counter and FSM (RUN). Every output reads 0 during reset and until the first load.
- Latency: MEM inputs are captured on edge k and appear on the WB outputs in cycle k+1. o_write_data is combinational from the latch and the RAM data in that cycle.
- A stall of n cycles holds all outputs constant for n cycles. The register file may be rewritten with identical data each stalled cycle.
- The retiring HALT is counted. o_halted rises in the cycle after the HALT's retire edge. o_reg_write is 0 from then on.
- Flush and stall in the same cycle: the flush wins and the latch becomes a bubble.

## Test plan
- Load-word path: MEM presents valid, ctrl=2'b11, rd=5, addr=0x10, with RAM returning 0xDEADBEEF next cycle -> WB cycle: o_reg_write=1, o_write_register=5, o_write_data=0xDEADBEEF; counter 0->1 on the advancing edge.
- R-type with $0 destination: ctrl=2'b10, rd=0, addr=0x1234 -> o_write_data=0x1234, o_reg_write=0, counter still increments.
- Stall over a load: load in WB, i_enable=0 for 3 cycles while i_read_data changes to 0x0 -> o_write_data stays 0xCAFEF00D (original); counter unchanged until i_enable=1.
- Flush with simultaneous stall: i_flush=1, i_enable=0, valid instruction at MEM -> next cycle o_wb_valid=0, o_reg_write=0, counter unchanged.
- HALT retire: 4 instructions then HALT with i_enable=1 -> o_retired_count=5, o_halted=1; further valid inputs leave all outputs and the counter frozen.
- Asynchronous reset mid-run: i_rst pulled low between edges while o_halted=1 -> all outputs 0 immediately; after release, the next load proceeds as in scenario 1.

Source files
------------

// File: rtl/seg_write_back.sv
// seg_write_back: MEM/WB pipeline register, write-back mux and commit FSM.
// A HALT retiring freezes the stage until reset; stalled loads keep their RAM data.
module seg_write_back #(
   parameter int LEN        = 32,
   parameter int NB_ADDR    = 5,
   parameter int NB_CTRL_WB = 2,
   parameter int NB_CNT     = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic                  i_halt,
   input  logic [LEN-1:0]        i_read_data,
   input  logic [LEN-1:0]        i_address,
   input  logic [NB_ADDR-1:0]    i_write_register,
   input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
   output logic                  o_reg_write,
   output logic [NB_ADDR-1:0]    o_write_register,
   output logic [LEN-1:0]        o_write_data,
   output logic                  o_wb_valid,
   output logic                  o_halted,
   output logic [NB_CNT-1:0]     o_retired_count
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t                  state;
   logic                    wb_valid, wb_halt, hold_valid;
   logic [LEN-1:0]          wb_address, hold_data, read_data;
   logic [NB_ADDR-1:0]      wb_write_register;
   logic [NB_CTRL_WB-1:0]   wb_ctrl;
   logic [NB_CNT-1:0]       retired_count;
   logic                    run, retire;
   assign run    = (state == RUN);
   assign retire = run & wb_valid & i_enable & ~i_flush;
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         state             <= RUN;
         wb_valid          <= 1'b0;
         wb_halt           <= 1'b0;
         wb_address        <= '0;
         wb_write_register <= '0;
         wb_ctrl           <= '0;
         hold_valid        <= 1'b0;
         hold_data         <= '0;
         retired_count     <= '0;
      end else if (run) begin
         if (retire) begin
            if (~&retired_count) retired_count <= retired_count + NB_CNT'(1);
            if (wb_halt) state <= HALTED;
         end
         if (i_flush) begin
            wb_valid <= 1'b0;
            wb_halt  <= 1'b0;
            wb_ctrl  <= '0;
         end else if (i_enable) begin
            wb_valid          <= i_valid;
            wb_halt           <= i_valid & i_halt;
            wb_ctrl           <= i_valid ? i_ctrl_wb_bus : '0;
            wb_address        <= i_address;
            wb_write_register <= i_write_register;
         end
         // capture RAM output on the first stalled edge so a stalled load stays stable
         if (i_enable | i_flush) hold_valid <= 1'b0;
         else if (!hold_valid) begin
            hold_data  <= i_read_data;
            hold_valid <= 1'b1;
         end
      end
   assign read_data        = hold_valid ? hold_data : i_read_data;
   assign o_write_data     = wb_ctrl[0] ? read_data : wb_address;
   assign o_reg_write      = wb_valid & wb_ctrl[1] & (|wb_write_register) & run;
   assign o_write_register = wb_write_register;
   assign o_wb_valid       = wb_valid;
   assign o_halted         = (state == HALTED);
   assign o_retired_count  = retired_count;
endmodule

// File: tb/tb_seg_write_back.sv
// tb_seg_write_back: randomized and directed scoreboard bench for seg_write_back.
module tb_seg_write_back;
   logic        i_clk = 1'b0, i_rst = 1'b1, i_enable = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_halt = 1'b0;
   logic [31:0] i_read_data = '0, i_address = '0;
   logic [4:0]  i_write_register = '0;
   logic [1:0]  i_ctrl_wb_bus = '0;
   logic        o_reg_write, o_wb_valid, o_halted;
   logic [4:0]  o_write_register;
   logic [31:0] o_write_data, o_retired_count;

   seg_write_back dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
      .i_valid(i_valid), .i_halt(i_halt), .i_read_data(i_read_data),
      .i_address(i_address), .i_write_register(i_write_register),
      .i_ctrl_wb_bus(i_ctrl_wb_bus), .o_reg_write(o_reg_write),
      .o_write_register(o_write_register), .o_write_data(o_write_data),
      .o_wb_valid(o_wb_valid), .o_halted(o_halted), .o_retired_count(o_retired_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        rw, v, h, care;
      logic [4:0]  wr;
      logic [31:0] wd, cnt;
   } exp_t;
   exp_t q[$];
   int n_cmp = 0, n_err = 0;

   // reference model: the instruction sitting in WB plus the commit bookkeeping
   logic        m_v, m_h, m_halted, m_fresh, m_stall, m_stalled_rd_valid;
   logic [1:0]  m_ctrl;
   logic [4:0]  m_wr;
   logic [31:0] m_addr, m_cnt, m_stalled_rd;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_v = 0; m_h = 0; m_halted = 0; m_fresh = 1; m_ctrl = 0; m_wr = 0; m_addr = 0;
      m_cnt = 0; m_stalled_rd_valid = 0; m_stalled_rd = 0;
   endtask

   task automatic drive(bit en, bit fl, bit v, bit h, logic [1:0] c, logic [4:0] wr,
                        logic [31:0] a, logic [31:0] rd);
      exp_t e;
      i_enable = en; i_flush = fl; i_valid = v; i_halt = h; i_ctrl_wb_bus = c;
      i_write_register = wr; i_address = a; i_read_data = rd;
      e.v    = m_v;
      e.h    = m_halted;
      e.cnt  = m_cnt;
      e.rw   = m_v & m_ctrl[1] & (m_wr != 0) & !m_halted;
      e.wr   = m_wr;
      e.wd   = m_ctrl[0] ? (m_stalled_rd_valid ? m_stalled_rd : rd) : m_addr;
      e.care = m_v | m_fresh;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge i_clk);
      if (!m_halted) begin
         if (m_v && i_enable && !i_flush) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (m_h) m_halted = 1;
         end
         if (i_enable || i_flush) m_stalled_rd_valid = 0;
         else if (!m_stalled_rd_valid) begin
            m_stalled_rd = i_read_data;
            m_stalled_rd_valid = 1;
         end
         if (i_flush) begin
            m_v = 0; m_h = 0; m_ctrl = 0; m_fresh = 0;
         end else if (i_enable) begin
            m_v = i_valid; m_h = i_valid & i_halt; m_ctrl = i_valid ? i_ctrl_wb_bus : 2'b00;
            m_addr = i_address; m_wr = i_write_register; m_fresh = 0;
         end
      end
      #1;
   endtask

   task automatic reset_dut();
      i_rst = 1'b0;
      #1;
      chk("rst_reg_write", o_reg_write, 0);
      chk("rst_write_register", o_write_register, 0);
      chk("rst_write_data", o_write_data, 0);
      chk("rst_wb_valid", o_wb_valid, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_count", o_retired_count, 0);
      model_reset();
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
   endtask

   task automatic load_word_scenario();
      drive(1, 0, 1, 0, 2'b11, 5'd5, 32'h10, $urandom);
      step();
      drive(1, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'hDEADBEEF);
      #1;
      chk("lw_write_data", o_write_data, 32'hDEADBEEF);
      chk("lw_reg_write", o_reg_write, 1);
      chk("lw_write_register", o_write_register, 5);
      step();
      chk("lw_count", o_retired_count, 1);
   endtask

   always @(negedge i_clk)
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("sb_reg_write", o_reg_write, e.rw);
         chk("sb_wb_valid", o_wb_valid, e.v);
         chk("sb_halted", o_halted, e.h);
         chk("sb_count", o_retired_count, e.cnt);
         if (e.care) begin
            chk("sb_write_register", o_write_register, e.wr);
            chk("sb_write_data", o_write_data, e.wd);
         end
      end

   initial begin
      model_reset();
      #1;
      reset_dut();
      load_word_scenario();
      drive(1, 0, 1, 0, 2'b10, 5'd0, 32'h1234, $urandom);
      step();
      drive(1, 0, 0, 0, 2'b00, 5'd0, 32'h0, $urandom);
      #1;
      chk("r0_write_data", o_write_data, 32'h1234);
      chk("r0_reg_write", o_reg_write, 0);
      step();
      chk("r0_count", o_retired_count, 2);
      drive(1, 0, 1, 0, 2'b11, 5'd7, 32'h20, $urandom);
      step();
      drive(0, 0, 1, 0, 2'b11, 5'd9, 32'h44, 32'hCAFEF00D);
      #1;
      chk("stall_first_data", o_write_data, 32'hCAFEF00D);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 2'b11, 5'd9, 32'h44, 32'h0);
         #1;
         chk("stall_hold_data", o_write_data, 32'hCAFEF00D);
         chk("stall_count", o_retired_count, 2);
         step();
      end
      drive(1, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      #1;
      chk("stall_release_data", o_write_data, 32'hCAFEF00D);
      step();
      chk("stall_release_count", o_retired_count, 3);
      drive(1, 0, 1, 0, 2'b10, 5'd3, 32'h55, $urandom);
      step();
      drive(0, 1, 1, 0, 2'b10, 5'd4, 32'h66, $urandom);
      step();
      drive(1, 0, 0, 0, 2'b00, 5'd0, 32'h0, $urandom);
      #1;
      chk("flush_wb_valid", o_wb_valid, 0);
      chk("flush_reg_write", o_reg_write, 0);
      chk("flush_count", o_retired_count, 3);
      step();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 0,
               2'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
         step();
      end
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, 0, 2'b10, 5'(i + 1), $urandom, $urandom);
         step();
      end
      drive(1, 0, 1, 1, 2'b00, 5'd0, 32'h0, $urandom);
      step();
      drive(1, 0, 1, 0, 2'b10, 5'd6, 32'h77, $urandom);
      step();
      chk("halt_halted", o_halted, 1);
      chk("halt_count", o_retired_count, 5);
      for (int i = 0; i < 8; i++) begin
         drive(1, $urandom_range(0, 1), 1, $urandom_range(0, 1), 2'($urandom), 5'($urandom), $urandom, $urandom);
         #1;
         chk("frozen_reg_write", o_reg_write, 0);
         step();
         chk("frozen_count", o_retired_count, 5);
         chk("frozen_halted", o_halted, 1);
      end
      reset_dut();
      load_word_scenario();
      @(negedge i_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
